// File: rtl/riscv_if_prefetch.sv
// riscv_if_prefetch: instruction-fetch stage with a DEPTH-entry prefetch queue.
// Issues word fetches ahead of decode, buffers {pc, instr} pairs and hands them
// to ID over a valid/ready handshake. EX/ID redirects flush everything.
// Optional feature macro: IF_MISALIGN_EXC_EN. When defined, a redirect target
// with non-zero low bits is presented as a single exception entry (o_exc=1)
// and fetching halts until the next redirect. When undefined, the low bits are
// cleared and o_exc is tied to 0.
module riscv_if_prefetch #(
    parameter int DEPTH      = 4,
    parameter int XLEN       = 32,
    parameter int BOOT_ALIGN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_boot_addr,
    input  logic            i_ex_jmp,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_id_jmp,
    input  logic [XLEN-1:0] i_id_target,
    output logic            o_rd_req,
    output logic [XLEN-1:0] o_rd_addr,
    output logic [3:0]      o_rd_be,
    input  logic            i_rd_gnt,
    input  logic [XLEN-1:0] i_rd_data,
    output logic            o_wr_req,
    output logic [XLEN-1:0] o_wr_addr,
    output logic [XLEN-1:0] o_wr_data,
    output logic [3:0]      o_wr_be,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output logic            o_exc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << BOOT_ALIGN) - XLEN'(1));

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            pending_q, pending_d;
    logic            drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   in_flight;
    logic            head_vld;
    logic            grant;
    logic            push;
    logic            pop;
    logic            exc_active;
    logic            stop_fetch;

    assign redirect  = i_ex_jmp | i_id_jmp;
    assign target    = i_ex_jmp ? i_ex_target : i_id_target;
    assign in_flight = count_q + CW'(pending_q);
    assign head_vld  = (count_q != '0);

    // drop_q covers the first cycle after reset: no request, and any response
    // belonging to a grant issued before reset is ignored.
    assign o_rd_req  = ~drop_q & ~stop_fetch & ~redirect & (in_flight < CW'(DEPTH));
    assign o_rd_addr = fetch_pc_q;
    assign grant     = o_rd_req & i_rd_gnt;
    assign push      = pending_q & ~drop_q & ~redirect;
    assign pop       = head_vld & i_ready;

    assign o_rd_be   = 4'hf;
    assign o_wr_req  = 1'b0;
    assign o_wr_addr = '0;
    assign o_wr_data = '0;
    assign o_wr_be   = 4'h0;

`ifdef IF_MISALIGN_EXC_EN
    logic            exc_q, exc_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] exc_pc_q;
    logic            misalign;

    assign misalign   = (target[1:0] != 2'b00);
    assign exc_active = exc_q;
    assign stop_fetch = halt_q;

    // Exception entry lives until ID takes it; the halt lasts until the next redirect.
    always_comb begin
        exc_d  = exc_q;
        halt_d = halt_q;
        if (redirect) begin
            exc_d  = misalign;
            halt_d = misalign;
        end else if (exc_q && i_ready) begin
            exc_d = 1'b0;
        end
    end

    // Exception state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q  <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            exc_q  <= exc_d;
            halt_q <= halt_d;
        end
    end

    // Raw (unaligned) redirect target reported with the exception entry.
    always_ff @(posedge clk) begin
        if (redirect) exc_pc_q <= target;
    end

    assign o_exc = exc_q;
`else
    assign exc_active = 1'b0;
    assign stop_fetch = 1'b0;
    assign o_exc      = 1'b0;
`endif

    assign o_valid = head_vld | exc_active;
`ifdef IF_MISALIGN_EXC_EN
    assign o_pc    = exc_active ? exc_pc_q : (head_vld ? pc_mem[rptr_q] : '0);
`else
    assign o_pc    = head_vld ? pc_mem[rptr_q] : '0;
`endif
    assign o_instr = (head_vld && !exc_active) ? instr_mem[rptr_q] : '0;

    // Next-state for fetch pointer, outstanding flag and queue bookkeeping;
    // a redirect overrides any push/pop in the same cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pending_d  = grant;
        drop_d     = 1'b0;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (redirect) begin
            fetch_pc_d = target & ALIGN_MASK;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end else begin
            if (drop_q) begin
                fetch_pc_d = i_boot_addr & ALIGN_MASK;
            end else if (grant) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= '0;
            pending_q  <= 1'b0;
            drop_q     <= 1'b1;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Queue storage and pc of the in-flight request; no reset needed on data.
    always_ff @(posedge clk) begin
        if (grant) rsp_pc_q <= fetch_pc_q;
        if (push) begin
            pc_mem[wptr_q]    <= rsp_pc_q;
            instr_mem[wptr_q] <= i_rd_data;
        end
    end

endmodule

// File: tb/tb_riscv_if_prefetch.sv
// Testbench for riscv_if_prefetch: scenario tasks driven against a
// transaction-level model of the fetch stream (next pc, items in flight).
module tb_riscv_if_prefetch;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk, rst_n;
    logic [XLEN-1:0] i_boot_addr, i_ex_target, i_id_target, i_rd_data;
    logic            i_ex_jmp, i_id_jmp, i_rd_gnt, i_ready;
    logic            o_rd_req, o_wr_req, o_valid, o_exc;
    logic [XLEN-1:0] o_rd_addr, o_wr_addr, o_wr_data, o_pc, o_instr;
    logic [3:0]      o_rd_be, o_wr_be;

    riscv_if_prefetch #(.DEPTH(DEPTH), .XLEN(XLEN), .BOOT_ALIGN(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_boot_addr(i_boot_addr),
        .i_ex_jmp(i_ex_jmp), .i_ex_target(i_ex_target),
        .i_id_jmp(i_id_jmp), .i_id_target(i_id_target),
        .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .o_rd_be(o_rd_be),
        .i_rd_gnt(i_rd_gnt), .i_rd_data(i_rd_data),
        .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_be(o_wr_be),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_instr(o_instr), .o_exc(o_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic        s_req, s_valid, s_hs, s_gnt, s_exc;
    logic [31:0] s_addr, s_pc, s_instr;
    logic        e_req, e_valid, e_exc;
    logic [31:0] e_addr, e_pc, e_instr;

    // Model: exp_pc is the pc ID must receive next; occ counts fetches granted
    // since the last flush and not yet consumed by ID.
    int          occ;
    bit          gprev, boot_cyc, exc_pend, halted;
    logic [31:0] exp_pc, exc_raw;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset(input logic [31:0] boot);
        occ = 0; gprev = 0; boot_cyc = 1; exc_pend = 0; halted = 0;
        exp_pc = boot & ~32'h3; exc_raw = '0;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        rst_n = 1'b0; i_boot_addr = boot;
        i_ex_jmp = 0; i_id_jmp = 0; i_rd_gnt = 0; i_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset(boot);
    endtask

    // One clock: sample outputs mid-cycle, form expectations, advance the model,
    // and play the bus memory (data for a grant appears the following cycle).
    task automatic tick();
        logic        jmp;
        logic [31:0] tgt, gaddr;
        @(negedge clk);
        s_req = o_rd_req; s_addr = o_rd_addr; s_valid = o_valid;
        s_pc = o_pc; s_instr = o_instr; s_exc = o_exc;
        s_hs = o_valid & i_ready;
        s_gnt = o_rd_req & i_rd_gnt;
        jmp = i_ex_jmp | i_id_jmp;
        tgt = i_ex_jmp ? i_ex_target : i_id_target;
        e_req   = !boot_cyc && !halted && !jmp && (occ < DEPTH);
        e_addr  = exp_pc + 32'(occ * 4);
        e_valid = exc_pend || ((occ - int'(gprev)) > 0);
        e_pc    = exc_pend ? exc_raw : exp_pc;
        e_instr = exc_pend ? 32'h0 : memf(exp_pc);
        e_exc   = exc_pend;
        gaddr = s_addr;
        if (s_hs) begin
            if (exc_pend) exc_pend = 0;
            else begin exp_pc = exp_pc + 32'd4; occ--; end
        end
        if (s_gnt) occ++;
        gprev = s_gnt;
        boot_cyc = 0;
        if (jmp) begin
            occ = 0; gprev = 0;
`ifdef IF_MISALIGN_EXC_EN
            if (tgt[1:0] != 2'b00) begin
                exc_pend = 1; halted = 1; exc_raw = tgt;
            end else begin
                exc_pend = 0; halted = 0; exp_pc = tgt & ~32'h3;
            end
`else
            exp_pc = tgt & ~32'h3;
`endif
        end
        cyc++;
        @(posedge clk);
        #1 i_rd_data = s_gnt ? memf(gaddr) : $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; i_boot_addr = 32'h1003; i_rd_data = '0;
        i_ex_jmp = 0; i_id_jmp = 0; i_ex_target = '0; i_id_target = '0;
        i_rd_gnt = 0; i_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        n_chk++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
        n_chk++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", o_instr); end
        n_chk++; if (o_exc !== 1'b0) begin n_fail++; $display("FAIL reset_exc got=%b exp=0", o_exc); end
        n_chk++; if (o_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", o_rd_req); end
        n_chk++; if (o_wr_req !== 1'b0) begin n_fail++; $display("FAIL tie_wr_req got=%b exp=0", o_wr_req); end
        n_chk++; if (o_wr_be !== 4'h0) begin n_fail++; $display("FAIL tie_wr_be got=%h exp=0", o_wr_be); end
        n_chk++; if (o_wr_addr !== 32'h0) begin n_fail++; $display("FAIL tie_wr_addr got=%h exp=0", o_wr_addr); end
        n_chk++; if (o_wr_data !== 32'h0) begin n_fail++; $display("FAIL tie_wr_data got=%h exp=0", o_wr_data); end
        n_chk++; if (o_rd_be !== 4'hf) begin n_fail++; $display("FAIL tie_rd_be got=%h exp=f", o_rd_be); end
        do_reset(32'h1003);
    endtask

    task automatic test_boot();
        int first_g = -1;
        int first_v = -1;
        logic [31:0] hp[$];
        i_ready = 1; i_rd_gnt = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_chk++; if (s_req !== e_req) begin n_fail++; $display("FAIL boot_req cyc=%0d got=%b exp=%b", cyc, s_req, e_req); end
            if (s_req) begin n_chk++; if (s_addr !== e_addr) begin n_fail++; $display("FAIL boot_addr cyc=%0d got=%h exp=%h", cyc, s_addr, e_addr); end end
            n_chk++; if (s_valid !== e_valid) begin n_fail++; $display("FAIL boot_valid cyc=%0d got=%b exp=%b", cyc, s_valid, e_valid); end
            if (s_hs) begin n_chk++; if ({s_pc, s_instr, s_exc} !== {e_pc, e_instr, e_exc}) begin n_fail++; $display("FAIL boot_out cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, s_pc, s_instr, s_exc, e_pc, e_instr, e_exc); end end
            if (s_gnt && first_g < 0) first_g = c;
            if (s_valid && first_v < 0) first_v = c;
            if (s_hs) hp.push_back(s_pc);
        end
        n_chk++; if (first_g < 0 || first_v - first_g != 2) begin n_fail++; $display("FAIL boot_latency got=%0d exp=2", first_v - first_g); end
        n_chk++;
        if (hp.size() < 3 || hp[0] !== 32'h1000 || hp[1] !== 32'h1004 || hp[2] !== 32'h1008) begin
            n_fail++; $display("FAIL boot_seq got_n=%0d first=%h exp=1000,1004,1008", hp.size(), (hp.size() > 0) ? hp[0] : 32'hx);
        end
    endtask

    task automatic test_stall_fill();
        int ng = 0;
        i_ready = 0; i_rd_gnt = 1;
        i_id_jmp = 1; i_id_target = 32'h6000;
        tick();
        n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL stall_jmp_req got=%b exp=0", s_req); end
        i_id_jmp = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_chk++; if (s_req !== e_req) begin n_fail++; $display("FAIL stall_req cyc=%0d got=%b exp=%b", cyc, s_req, e_req); end
            n_chk++; if (s_valid !== e_valid) begin n_fail++; $display("FAIL stall_valid cyc=%0d got=%b exp=%b", cyc, s_valid, e_valid); end
            if (s_valid) begin n_chk++; if (s_pc !== 32'h6000) begin n_fail++; $display("FAIL stall_hold cyc=%0d got=%h exp=6000", cyc, s_pc); end end
            if (s_gnt) ng++;
        end
        n_chk++; if (ng != DEPTH) begin n_fail++; $display("FAIL stall_grants got=%0d exp=%0d", ng, DEPTH); end
        n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL stall_full_req got=%b exp=0", s_req); end
        i_ready = 1;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            n_chk++;
            if (!s_hs || s_pc !== 32'h6000 + 32'(4 * k) || s_instr !== memf(32'h6000 + 32'(4 * k))) begin
                n_fail++; $display("FAIL stall_drain k=%0d got=%b/%h exp=1/%h", k, s_hs, s_pc, 32'h6000 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] hp[$];
        i_ready = 1; i_rd_gnt = 1;
        i_id_jmp = 1; i_id_target = 32'h2000;
        tick();
        i_id_jmp = 0;
        repeat (2) begin
            tick();
            if (s_hs) hp.push_back(s_pc);
        end
        i_rd_gnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++; if (s_req !== 1'b1 || s_addr !== 32'h2008) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/2008", cyc, s_req, s_addr); end
            if (s_hs) hp.push_back(s_pc);
        end
        i_rd_gnt = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_chk++; if (s_req !== e_req) begin n_fail++; $display("FAIL bp_req cyc=%0d got=%b exp=%b", cyc, s_req, e_req); end
            if (s_req) begin n_chk++; if (s_addr !== e_addr) begin n_fail++; $display("FAIL bp_addr cyc=%0d got=%h exp=%h", cyc, s_addr, e_addr); end end
            n_chk++; if (s_valid !== e_valid) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, s_valid, e_valid); end
            if (s_hs) hp.push_back(s_pc);
        end
        n_chk++;
        if (hp.size() < 6) begin n_fail++; $display("FAIL bp_count got=%0d exp>=6", hp.size()); end
        for (int k = 0; k < hp.size(); k++) begin
            n_chk++; if (hp[k] !== 32'h2000 + 32'(4 * k)) begin n_fail++; $display("FAIL bp_seq k=%0d got=%h exp=%h", k, hp[k], 32'h2000 + 32'(4 * k)); end
        end
    endtask

    task automatic test_redirect_priority();
        logic [31:0] hp[$];
        i_ready = 1; i_rd_gnt = 1;
        i_id_jmp = 1; i_id_target = 32'h7000;
        tick();
        i_id_jmp = 0;
        repeat (4) tick();
        n_chk++; if (s_gnt !== 1'b1) begin n_fail++; $display("FAIL prio_pending got=%b exp=1", s_gnt); end
        i_ex_jmp = 1; i_ex_target = 32'h4000; i_id_jmp = 1; i_id_target = 32'h5000;
        tick();
        n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL prio_jmp_req got=%b exp=0", s_req); end
        i_ex_jmp = 0; i_id_jmp = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_chk++; if (s_valid !== e_valid) begin n_fail++; $display("FAIL prio_valid cyc=%0d got=%b exp=%b", cyc, s_valid, e_valid); end
            if (s_hs) begin
                hp.push_back(s_pc);
                n_chk++; if ({s_pc, s_instr} !== {e_pc, e_instr}) begin n_fail++; $display("FAIL prio_out cyc=%0d got=%h/%h exp=%h/%h", cyc, s_pc, s_instr, e_pc, e_instr); end
            end
        end
        n_chk++; if (hp.size() == 0 || hp[0] !== 32'h4000) begin n_fail++; $display("FAIL prio_first got=%h exp=4000", (hp.size() > 0) ? hp[0] : 32'hx); end
    endtask

    task automatic test_wrap();
        logic [31:0] hp[$];
        i_ready = 1; i_rd_gnt = 1;
        i_id_jmp = 1; i_id_target = 32'hFFFF_FFF8;
        tick();
        i_id_jmp = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_req) begin n_chk++; if (s_addr !== e_addr) begin n_fail++; $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", cyc, s_addr, e_addr); end end
            if (s_hs) hp.push_back(s_pc);
        end
        n_chk++;
        if (hp.size() < 3 || hp[0] !== 32'hFFFF_FFF8 || hp[1] !== 32'hFFFF_FFFC || hp[2] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_seq got_n=%0d first3=%h,%h,%h exp=fffffff8,fffffffc,0", hp.size(),
                (hp.size() > 0) ? hp[0] : 32'hx, (hp.size() > 1) ? hp[1] : 32'hx, (hp.size() > 2) ? hp[2] : 32'hx);
        end
    endtask

    task automatic test_misalign();
        i_ready = 1; i_rd_gnt = 1;
        i_id_jmp = 1; i_id_target = 32'h3002;
        tick();
        i_id_jmp = 0;
`ifdef IF_MISALIGN_EXC_EN
        tick();
        n_chk++;
        if ({s_valid, s_exc, s_pc, s_instr} !== {1'b1, 1'b1, 32'h3002, 32'h0}) begin
            n_fail++; $display("FAIL mis_exc got=%b/%b/%h/%h exp=1/1/3002/0", s_valid, s_exc, s_pc, s_instr);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL mis_halt cyc=%0d got=%b/%b exp=0/0", cyc, s_req, s_valid); end
        end
        i_id_jmp = 1; i_id_target = 32'h3100;
        tick();
        i_id_jmp = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (s_hs) begin n_chk++; if ({s_pc, s_exc} !== {e_pc, e_exc}) begin n_fail++; $display("FAIL mis_resume cyc=%0d got=%h/%b exp=%h/%b", cyc, s_pc, s_exc, e_pc, e_exc); end end
        end
`else
        begin
            bit seen = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (s_hs && !seen) begin
                    seen = 1;
                    n_chk++; if (s_pc !== 32'h3000 || s_exc !== 1'b0) begin n_fail++; $display("FAIL mis_off got=%h/%b exp=3000/0", s_pc, s_exc); end
                end
            end
            n_chk++; if (!seen) begin n_fail++; $display("FAIL mis_off_none got=0 exp=1 handshakes"); end
        end
`endif
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 1500; c++) begin
            i_rd_gnt = ($urandom_range(0, 3) != 0);
            i_ready  = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 39);
            i_ex_jmp = (r == 0) || (r == 2);
            i_id_jmp = (r == 1) || (r == 2);
            i_ex_target = ($urandom & ~32'h3) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            i_id_target = ($urandom & ~32'h3) | (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
            tick();
            n_chk++; if (s_req !== e_req) begin n_fail++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, s_req, e_req); end
            if (s_req) begin n_chk++; if (s_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, s_addr, e_addr); end end
            n_chk++; if (s_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, s_valid, e_valid); end
            if (s_hs) begin n_chk++; if ({s_pc, s_instr, s_exc} !== {e_pc, e_instr, e_exc}) begin n_fail++; $display("FAIL rnd_out cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, s_pc, s_instr, s_exc, e_pc, e_instr, e_exc); end end
        end
        i_ex_jmp = 0; i_id_jmp = 0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] hp[$];
        i_ready = 1; i_rd_gnt = 1;
        i_id_jmp = 1; i_id_target = 32'h9000;
        tick();
        i_id_jmp = 0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({o_valid, o_rd_req, o_exc} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_ctl got=%b%b%b exp=000", o_valid, o_rd_req, o_exc); end
        n_chk++; if ({o_pc, o_instr} !== 64'h0) begin n_fail++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", o_pc, o_instr); end
        do_reset(32'h8000);
        i_ready = 1; i_rd_gnt = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_chk++; if (s_req !== e_req) begin n_fail++; $display("FAIL mid_req cyc=%0d got=%b exp=%b", cyc, s_req, e_req); end
            n_chk++; if (s_valid !== e_valid) begin n_fail++; $display("FAIL mid_valid cyc=%0d got=%b exp=%b", cyc, s_valid, e_valid); end
            if (s_hs) hp.push_back(s_pc);
        end
        n_chk++; if (hp.size() == 0 || hp[0] !== 32'h8000) begin n_fail++; $display("FAIL mid_first got=%h exp=8000", (hp.size() > 0) ? hp[0] : 32'hx); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_stall_fill();
        test_back_pressure();
        test_redirect_priority();
        test_wrap();
        test_misalign();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
